// File: rtl/rf_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rf_pkg
// Brief    : Shared register-file types and constants for the writeback
//            arbiter and its scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
package rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // One register-file write request as seen at the write port.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_DATA_W-1:0] data;
    } wr_req_t;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rf_scoreboard
// Brief    : Pending-write scoreboard for long-latency destinations. Tracks
//            one busy bit per architectural register, gates issue of a new
//            long op to an already-pending destination and raises a read
//            hazard for decode.
// Revision : 1.0 - initial release
// ============================================================================
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_issue_valid,
    input  logic [ADDR_W-1:0] i_issue_rd,
    input  logic              i_clr_en,
    input  logic [ADDR_W-1:0] i_clr_idx,
    input  logic [ADDR_W-1:0] i_rs,
    input  logic [ADDR_W-1:0] i_rt,
    output logic              o_issue_ready,
    output logic              o_hazard_stall,
    output logic              o_busy_any
);

    localparam int c_num_entries = 2 ** ADDR_W;

    logic [c_num_entries-1:0] r_busy;
    logic [c_num_entries-1:0] w_busy_nxt;
    logic                     r_busy_any;
    logic                     w_set_en;

    // Register 0 is never tracked, so it is always ready and never hazards.
    assign o_issue_ready  = (i_issue_rd == '0) || !r_busy[i_issue_rd];
    assign w_set_en       = i_issue_valid && o_issue_ready && (i_issue_rd != '0);
    assign o_hazard_stall = ((i_rs != '0) && r_busy[i_rs]) ||
                            ((i_rt != '0) && r_busy[i_rt]);
    assign o_busy_any     = r_busy_any;

    // Next busy vector: clear first, then set, so a same-index set wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_clr_en) begin
            w_busy_nxt[i_clr_idx] = 1'b0;
        end
        if (w_set_en) begin
            w_busy_nxt[i_issue_rd] = 1'b1;
        end
    end

    // Busy bits and the registered summary flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy     <= '0;
            r_busy_any <= 1'b0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_busy_any <= |w_busy_nxt;
        end
    end

`ifndef SYNTHESIS
    // A long-unit result should land on a pending destination. The case where
    // the same index is re-issued in the very cycle it returns is legitimate.
    a_clear_of_pending : assert property (
        @(posedge clk) disable iff (!rst)
        (i_clr_en && !(w_set_en && (i_issue_rd == i_clr_idx))) |-> r_busy[i_clr_idx]
    );
`endif

endmodule : rf_scoreboard
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rf_wb_arbiter
// Brief    : Shares the single register-file write port between pipeline
//            writeback (A) and a long-latency result source (B). A has
//            priority; B is forced through after STARVE_MAX lost cycles.
//            Drives the registered reg_file write port and hosts the
//            pending-write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_W     = REG_DATA_W,
    parameter int ADDR_W     = REG_ADDR_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              issue_ready,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic              hazard_stall,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              reg_write,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] write_data,
    output logic              busy_any
);

    localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

    logic [3:0]        r_starve_cnt;
    logic              w_force_b;
    logic              w_a_ready;
    logic              w_b_ready;
    logic              w_grant;
    logic [ADDR_W-1:0] w_grant_rd;
    logic [DATA_W-1:0] w_grant_data;
    logic              r_reg_write;
    logic [ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0] r_write_data;

    // A wins by default; B is forced once it has lost STARVE_MAX cycles.
    assign w_force_b    = b_valid && (r_starve_cnt == c_starve_max);
    assign w_b_ready    = b_valid && (!a_valid || w_force_b);
    assign w_a_ready    = a_valid && !w_force_b;
    assign w_grant      = w_a_ready || w_b_ready;
    assign w_grant_rd   = w_b_ready ? b_rd   : a_rd;
    assign w_grant_data = w_b_ready ? b_data : a_data;

    assign a_ready    = w_a_ready;
    assign b_ready    = w_b_ready;
    assign reg_write  = r_reg_write;
    assign rd         = r_rd;
    assign write_data = r_write_data;

    // Count consecutive cycles B waits; restart whenever it wins or withdraws.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve_cnt <= '0;
        end else if (!b_valid || w_b_ready) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != c_starve_max) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    // Register the granted request; a grant to r0 is consumed without a write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reg_write  <= 1'b0;
            r_rd         <= '0;
            r_write_data <= '0;
        end else if (w_grant) begin
            r_reg_write  <= (w_grant_rd != '0);
            r_rd         <= w_grant_rd;
            r_write_data <= w_grant_data;
        end else begin
            r_reg_write  <= 1'b0;
        end
    end

    rf_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk            (clk),
        .rst            (rst),
        .i_issue_valid  (issue_valid),
        .i_issue_rd     (issue_rd),
        .i_clr_en       (w_b_ready),
        .i_clr_idx      (b_rd),
        .i_rs           (rs),
        .i_rt           (rt),
        .o_issue_ready  (issue_ready),
        .o_hazard_stall (hazard_stall),
        .o_busy_any     (busy_any)
    );

endmodule : rf_wb_arbiter
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rf_wb_arbiter
// Brief    : Directed self-checking bench for rf_wb_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        hazard_stall;
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        b_ready;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] write_data;
    logic        busy_any;

    int n_checks;
    int n_errors;

    rf_wb_arbiter #(
        .DATA_W     (32),
        .ADDR_W     (5),
        .STARVE_MAX (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_ready  (issue_ready),
        .rs           (rs),
        .rt           (rt),
        .hazard_stall (hazard_stall),
        .a_valid      (a_valid),
        .a_rd         (a_rd),
        .a_data       (a_data),
        .a_ready      (a_ready),
        .b_valid      (b_valid),
        .b_rd         (b_rd),
        .b_data       (b_data),
        .b_ready      (b_ready),
        .reg_write    (reg_write),
        .rd           (rd),
        .write_data   (write_data),
        .busy_any     (busy_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (reg_write !== 1'b0) begin n_errors++; $display("FAIL reset_reg_write got %b exp 0", reg_write); end
        n_checks++; if (rd !== 5'd0) begin n_errors++; $display("FAIL reset_rd got %0d exp 0", rd); end
        n_checks++; if (write_data !== 32'h0) begin n_errors++; $display("FAIL reset_write_data got %h exp 0", write_data); end
        n_checks++; if (issue_ready !== 1'b1) begin n_errors++; $display("FAIL reset_issue_ready got %b exp 1", issue_ready); end
        n_checks++; if (hazard_stall !== 1'b0) begin n_errors++; $display("FAIL reset_hazard got %b exp 0", hazard_stall); end
        n_checks++; if (busy_any !== 1'b0) begin n_errors++; $display("FAIL reset_busy_any got %b exp 0", busy_any); end
        rst = 1'b1;
    endtask

    task automatic test_a_only();
        a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h11112222;
        #1;
        n_checks++; if (a_ready !== 1'b1) begin n_errors++; $display("FAIL a_only_a_ready got %b exp 1", a_ready); end
        n_checks++; if (b_ready !== 1'b0) begin n_errors++; $display("FAIL a_only_b_ready got %b exp 0", b_ready); end
        step();
        a_valid = 1'b0;
        n_checks++; if (reg_write !== 1'b1) begin n_errors++; $display("FAIL a_only_reg_write got %b exp 1", reg_write); end
        n_checks++; if (rd !== 5'd3) begin n_errors++; $display("FAIL a_only_rd got %0d exp 3", rd); end
        n_checks++; if (write_data !== 32'h11112222) begin n_errors++; $display("FAIL a_only_data got %h exp 11112222", write_data); end
        step();
        n_checks++; if (reg_write !== 1'b0) begin n_errors++; $display("FAIL a_idle_reg_write got %b exp 0", reg_write); end
        n_checks++; if (rd !== 5'd3) begin n_errors++; $display("FAIL a_idle_rd_hold got %0d exp 3", rd); end
    endtask

    task automatic test_scoreboard();
        issue_valid = 1'b1; issue_rd = 5'd9; rs = 5'd9;
        #1;
        n_checks++; if (issue_ready !== 1'b1) begin n_errors++; $display("FAIL sb_issue_ready got %b exp 1", issue_ready); end
        n_checks++; if (hazard_stall !== 1'b0) begin n_errors++; $display("FAIL sb_hazard_pre got %b exp 0", hazard_stall); end
        step();
        n_checks++; if (issue_ready !== 1'b0) begin n_errors++; $display("FAIL sb_second_issue got %b exp 0", issue_ready); end
        n_checks++; if (busy_any !== 1'b1) begin n_errors++; $display("FAIL sb_busy_any got %b exp 1", busy_any); end
        n_checks++; if (hazard_stall !== 1'b1) begin n_errors++; $display("FAIL sb_hazard_rs got %b exp 1", hazard_stall); end
        issue_valid = 1'b0;
        rs = 5'd0; rt = 5'd9;
        #1;
        n_checks++; if (hazard_stall !== 1'b1) begin n_errors++; $display("FAIL sb_hazard_rt got %b exp 1", hazard_stall); end
        b_valid = 1'b1; b_rd = 5'd9; b_data = 32'hCAFE0009;
        #1;
        n_checks++; if (b_ready !== 1'b1) begin n_errors++; $display("FAIL sb_b_ready got %b exp 1", b_ready); end
        n_checks++; if (hazard_stall !== 1'b1) begin n_errors++; $display("FAIL sb_hazard_grant_cycle got %b exp 1", hazard_stall); end
        step();
        b_valid = 1'b0;
        n_checks++; if (hazard_stall !== 1'b0) begin n_errors++; $display("FAIL sb_hazard_cleared got %b exp 0", hazard_stall); end
        n_checks++; if (reg_write !== 1'b1 || rd !== 5'd9) begin n_errors++; $display("FAIL sb_b_write got we=%b rd=%0d exp we=1 rd=9", reg_write, rd); end
        n_checks++; if (busy_any !== 1'b0) begin n_errors++; $display("FAIL sb_busy_any_clear got %b exp 0", busy_any); end
        rt = 5'd0;
    endtask

    task automatic test_starvation();
        issue_valid = 1'b1; issue_rd = 5'd8;
        step();
        issue_valid = 1'b0;
        for (int round = 0; round < 2; round++) begin
            a_valid = 1'b1; b_valid = 1'b1; b_rd = 5'd8; b_data = 32'hDEADBEEF;
            for (int i = 0; i < 4; i++) begin
                a_rd = 5'(i + 1); a_data = 32'hA0000000 + 32'(i);
                #1;
                n_checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_errors++; $display("FAIL starve_a_wins r%0d c%0d got a=%b b=%b exp a=1 b=0", round, i, a_ready, b_ready); end
                step();
                n_checks++; if (reg_write !== 1'b1 || rd !== 5'(i + 1) || write_data !== 32'hA0000000 + 32'(i)) begin n_errors++; $display("FAIL starve_a_write r%0d c%0d got we=%b rd=%0d d=%h exp rd=%0d", round, i, reg_write, rd, write_data, i + 1); end
            end
            #1;
            n_checks++; if (b_ready !== 1'b1 || a_ready !== 1'b0) begin n_errors++; $display("FAIL starve_b_forced r%0d got a=%b b=%b exp a=0 b=1", round, a_ready, b_ready); end
            step();
            n_checks++; if (reg_write !== 1'b1 || rd !== 5'd8 || write_data !== 32'hDEADBEEF) begin n_errors++; $display("FAIL starve_b_write r%0d got we=%b rd=%0d d=%h exp we=1 rd=8 d=deadbeef", round, reg_write, rd, write_data); end
            b_valid = 1'b0;
            if (round == 0) begin
                issue_valid = 1'b1; issue_rd = 5'd8;
                #1;
                n_checks++; if (a_ready !== 1'b1) begin n_errors++; $display("FAIL starve_after_a_ready got %b exp 1", a_ready); end
                step();
                issue_valid = 1'b0;
            end
        end
        a_valid = 1'b0;
        step();
    endtask

    task automatic test_same_cycle();
        issue_valid = 1'b1; issue_rd = 5'd12;
        b_valid = 1'b1; b_rd = 5'd12; b_data = 32'h0000003C;
        rs = 5'd12;
        #1;
        n_checks++; if (issue_ready !== 1'b1 || b_ready !== 1'b1) begin n_errors++; $display("FAIL same_ready got ir=%b br=%b exp 1 1", issue_ready, b_ready); end
        step();
        issue_valid = 1'b0; b_valid = 1'b0;
        n_checks++; if (hazard_stall !== 1'b1) begin n_errors++; $display("FAIL same_set_wins got %b exp 1", hazard_stall); end
        n_checks++; if (busy_any !== 1'b1) begin n_errors++; $display("FAIL same_busy_any got %b exp 1", busy_any); end
        n_checks++; if (reg_write !== 1'b1 || rd !== 5'd12) begin n_errors++; $display("FAIL same_write got we=%b rd=%0d exp we=1 rd=12", reg_write, rd); end
        rs = 5'd0;
    endtask

    task automatic test_reg_zero();
        a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hFFFF0000;
        #1;
        n_checks++; if (a_ready !== 1'b1) begin n_errors++; $display("FAIL r0_a_ready got %b exp 1", a_ready); end
        step();
        a_valid = 1'b0;
        n_checks++; if (reg_write !== 1'b0) begin n_errors++; $display("FAIL r0_no_write got %b exp 0", reg_write); end
        n_checks++; if (rd !== 5'd0) begin n_errors++; $display("FAIL r0_rd got %0d exp 0", rd); end
    endtask

    task automatic test_reset_mid();
        issue_valid = 1'b1; issue_rd = 5'd5; rs = 5'd5;
        step();
        issue_valid = 1'b0;
        a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h00000077;
        n_checks++; if (hazard_stall !== 1'b1) begin n_errors++; $display("FAIL mid_pending got %b exp 1", hazard_stall); end
        step();
        a_valid = 1'b0;
        n_checks++; if (reg_write !== 1'b1 || rd !== 5'd7) begin n_errors++; $display("FAIL mid_write got we=%b rd=%0d exp we=1 rd=7", reg_write, rd); end
        #2;
        rst = 1'b0;
        issue_rd = 5'd12;
        #1;
        n_checks++; if (reg_write !== 1'b0) begin n_errors++; $display("FAIL mid_reg_write got %b exp 0", reg_write); end
        n_checks++; if (rd !== 5'd0 || write_data !== 32'h0) begin n_errors++; $display("FAIL mid_port_clear got rd=%0d d=%h exp 0 0", rd, write_data); end
        n_checks++; if (busy_any !== 1'b0) begin n_errors++; $display("FAIL mid_busy_any got %b exp 0", busy_any); end
        n_checks++; if (hazard_stall !== 1'b0) begin n_errors++; $display("FAIL mid_hazard got %b exp 0", hazard_stall); end
        n_checks++; if (issue_ready !== 1'b1) begin n_errors++; $display("FAIL mid_issue_ready got %b exp 1", issue_ready); end
        step();
        rst = 1'b1;
        rs = 5'd0;
        step();
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b0;
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
        rs          = 5'd0;
        rt          = 5'd0;
        a_valid     = 1'b0;
        a_rd        = 5'd0;
        a_data      = 32'h0;
        b_valid     = 1'b0;
        b_rd        = 5'd0;
        b_data      = 32'h0;

        test_reset();
        test_a_only();
        test_scoreboard();
        test_starvation();
        test_same_cycle();
        test_reg_zero();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_rf_wb_arbiter
`default_nettype wire
